bcd_nibble_tx: RTL and testbench
================================

# bcd_nibble_tx

Serial transmitter for single BCD digits. Accepts a 4-bit word over a valid/ready handshake, validates it as BCD (0–9), and rejects out-of-range words with a one-cycle `input_err` pulse. Valid digits are sent LSB-first on a single line as a 7-bit frame: start, 4 data bits, even parity, stop. It is the sending end of the digit link whose receiving end checks incoming nibbles and raises `input_err`.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; legal range ≥ 1.

**Ports**
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `in_data`  in  4: digit to send, LSB = bit 0.
- `in_valid`  in  1: `in_data` is offered.
- `in_ready`  out  1: block can accept a word this cycle.
- `tx_line`  out  1: serial output; idles high.
- `busy`  out  1: a frame is in progress (START through STOP).
- `input_err`  out  1: one-cycle pulse; the accepted word was > 9.

## Operation

- **States:** IDLE, START, DATA, PARITY, STOP.
- **Acceptance:** a word is accepted on a rising edge with `in_valid && in_ready`. `in_ready` = 1 only in IDLE and while `rst_n` = 1.
- **Invalid word (> 9):**
  - Not latched, no frame sent; stays in IDLE.
  - `input_err` = 1 for exactly the following cycle.
  - `in_ready` stays 1, so a new word may be accepted in that same cycle.
- **Valid word (≤ 9):**
  - Latched into a shift register; parity computed as XOR of the 4 bits.
  - Transitions to START.
- **Per-state behaviour** (each state lasts `CLKS_PER_BIT` cycles per bit):
  - START: `tx_line` = 0.
  - DATA: 4 bits, d0 first; `tx_line` = current shift-register LSB; shift on each bit boundary.
  - PARITY: `tx_line` = XOR(d3..d0), making the frame's total 1-count even.
  - STOP: `tx_line` = 1, then return to IDLE.
- **Busy behaviour:** `busy` = 1 in START, DATA, PARITY, STOP. `in_valid` is ignored while busy; no queuing.
- **Arithmetic:**
  - Bit-period counter is `$clog2(CLKS_PER_BIT)` bits wide, minimum 1 bit; counts 0..`CLKS_PER_BIT`−1 and wraps.
  - Data-bit index is 2 bits, 0..3.

## Timing

- **Reset values** (reset synchronous, active-low; held while `rst_n` = 0 at an edge):
  - `tx_line` = 1, `busy` = 0, `input_err` = 0, `in_ready` = 0.
  - State = IDLE; counters cleared.
- **First cycle after reset release:** `in_ready` = 1.
- **Latency:** accept at edge k; `tx_line` falls in the cycle after edge k.
- **Frame length:** 7 × `CLKS_PER_BIT` cycles, from the first START cycle to the last STOP cycle inclusive.
- **Back-to-back:** after the last STOP cycle, one IDLE cycle with `in_ready` = 1; the next start bit can begin one cycle later. Minimum spacing between start bits is 7·`CLKS_PER_BIT` + 1 cycles.
- **`input_err` timing:** asserted for one cycle, registered, in the cycle after the offending accept. It never coincides with `busy` from the same word.
- **Reset mid-frame:** at the reset edge, abort immediately; `tx_line` returns to 1 and the latched word is discarded. No partial frame resumes.
- **Simultaneous reset and `in_valid`:** reset wins; nothing is accepted.

## Structure

- **Package `bcd_tx_pkg`:**
  - State enum `tx_state_t`.
  - `FRAME_BITS` = 7, `DATA_BITS` = 4, `BCD_MAX` = 4'd9.
  - Function `is_bcd(logic [3:0])`.
- **Sub-module `bit_tick`:** parameterised by `CLKS_PER_BIT`. Counter that emits `tick` on the last cycle of each bit period; clear input driven by the FSM at frame start. Same clock and reset.
- **Top level:** FSM, shift register, parity register, `input_err` register.

## Test plan

- **Digit 5:** `CLKS_PER_BIT`=4, send 4'b0101 → `tx_line` per bit: 0, 1, 0, 1, 0, parity 0, stop 1; each bit held 4 cycles; `busy` high for 28 cycles; no `input_err`.
- **Digit 7:** send 4'd7 → data bits 1, 1, 1, 0, parity 1; `in_ready` returns 1 one cycle after the last stop cycle.
- **Invalid digits:** send 4'd12, then 4'd15 in consecutive cycles → `input_err` pulses on each following cycle; `tx_line` stays 1; `busy` stays 0.
- **Input while busy:** `in_valid` held high with 4'd3 during an active frame of 4'd9 → 4'd3 is accepted only at the IDLE cycle after 9's stop bit, then transmitted correctly.
- **Reset mid-frame:** `rst_n` low for 1 cycle during DATA bit 2 → next cycle `tx_line`=1, `busy`=0, `in_ready`=0; `in_ready`=1 the cycle after release; no stray frame.
- **Minimum divider:** `CLKS_PER_BIT`=1, back-to-back 9 then 0 → frames of 7 cycles each separated by one idle cycle; parity bits 0 and 0.

Source files
------------

// File: rtl/bcd_nibble_tx_pkg.sv
// Shared types, constants and helpers for the BCD nibble serial transmitter.
// Contents: FSM state enum, frame geometry constants, BCD range check.
package bcd_tx_pkg;

  localparam int unsigned FRAME_BITS = 7;
  localparam int unsigned DATA_BITS  = 4;
  localparam int unsigned STATE_W    = 3;
  localparam logic [3:0]  BCD_MAX    = 4'd9;

  typedef enum logic [STATE_W-1:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  // True when the nibble is a legal decimal digit.
  function automatic logic is_bcd(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_nibble_tx_if.sv
// Digit-in / serial-out bundle of the BCD nibble transmitter.
// master: digit source (drives in_data/in_valid, observes the rest).
// slave : transmitter (drives in_ready, tx_line, busy, input_err).
interface bcd_nibble_tx_if;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx_line;
  logic       busy;
  logic       input_err;

  modport master (
    output in_data, in_valid,
    input  in_ready, tx_line, busy, input_err
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, tx_line, busy, input_err
  );
endinterface

// File: rtl/bcd_nibble_tx_bit_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps.
// Ports: clk, rst_n (sync, active-low), clear (restart period at 0),
//        tick_c (high on the last cycle of each bit period).
module bit_tick #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Period counter; clear realigns it to the first cycle of a new frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick_c = (cnt == LAST);

endmodule

// File: rtl/bcd_nibble_tx.sv
// BCD digit serial transmitter: accepts a nibble over valid/ready, rejects
// words > 9 with a one-cycle input_err pulse, and sends legal digits LSB-first
// as start(0), d0..d3, even parity, stop(1), each bit CLKS_PER_BIT cycles.
// Ports: clk, rst_n (sync, active-low), bus (slave side of bcd_nibble_tx_if:
//        in_data/in_valid/in_ready handshake, tx_line, busy, input_err).
module bcd_nibble_tx
  import bcd_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_nibble_tx_if.slave   bus
);

  localparam logic [STATE_W-1:0] S_IDLE   = STATE_W'(TX_IDLE);
  localparam logic [STATE_W-1:0] S_START  = STATE_W'(TX_START);
  localparam logic [STATE_W-1:0] S_DATA   = STATE_W'(TX_DATA);
  localparam logic [STATE_W-1:0] S_PARITY = STATE_W'(TX_PARITY);
  localparam logic [STATE_W-1:0] S_STOP   = STATE_W'(TX_STOP);

  localparam int unsigned IDX_W    = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic [STATE_W-1:0]   state, state_d;
  logic [IDX_W-1:0]     bit_idx, idx_d;
  logic [DATA_BITS-1:0] shreg, sh_d;
  logic                 parity, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;
  logic                 frame_start_c;
  logic                 tick_c;

  bit_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (frame_start_c),
    .tick_c (tick_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      bit_idx <= '0;
      shreg   <= '0;
      parity  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_d;
      bit_idx <= idx_d;
      shreg   <= sh_d;
      parity  <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Next state plus next values of the registered outputs.
  // ready_q is 0 in the cycle right after reset, so it gates acceptance.
  always_comb begin
    state_d       = state;
    idx_d         = bit_idx;
    sh_d          = shreg;
    par_d         = parity;
    err_d         = 1'b0;
    frame_start_c = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.in_valid && ready_q) begin
          if (is_bcd(bus.in_data)) begin
            state_d       = S_START;
            sh_d          = bus.in_data;
            par_d         = ^bus.in_data;
            idx_d         = '0;
            frame_start_c = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_START: begin
        if (tick_c) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (tick_c) begin
          sh_d = {1'b0, shreg[DATA_BITS-1:1]};
          if (bit_idx == LAST_IDX) begin
            state_d = S_PARITY;
          end else begin
            idx_d = bit_idx + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (tick_c) state_d = S_STOP;
      end
      S_STOP: begin
        if (tick_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Line level for the state being entered, so tx follows accept by one cycle.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = sh_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase

    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  assign bus.tx_line   = tx_q;
  assign bus.busy      = busy_q;
  assign bus.in_ready  = ready_q;
  assign bus.input_err = err_q;

endmodule

// File: tb/tb_bcd_nibble_tx.sv
// Scoreboard bench for bcd_nibble_tx: a cycle-level handshake model predicts
// accept edges, pushes expected frames / error pulses, and a monitor checks
// the serial line bit by bit. A second instance at CLKS_PER_BIT=1 gets a
// directed back-to-back sequence.
module tb_bcd_nibble_tx;
  import bcd_tx_pkg::*;

  localparam int C    = 4;
  localparam int FLEN = FRAME_BITS * C;

  typedef struct {
    logic [3:0] d;
    int         start;
  } exp_frame_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst1_n;
  always #5 clk = ~clk;

  bcd_nibble_tx_if bus4 ();
  bcd_nibble_tx_if bus1 ();

  bcd_nibble_tx #(.CLKS_PER_BIT(C)) dut4 (.clk(clk), .rst_n(rst_n),  .bus(bus4));
  bcd_nibble_tx #(.CLKS_PER_BIT(1)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(bus1));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic rst_at_edge = 1'b0;
  bit done1 = 1'b0;

  exp_frame_t fq[$];
  int         eq[$];
  int         next_ok = 1 << 30;
  bit         last_acc;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= !rst_n;
  end

  // Line level of frame bit b (0=start .. 6=stop) for digit d.
  function automatic logic frame_bit(input int d, input int b);
    int p;
    p = 0;
    if (b == 0) return 1'b0;
    if (b <= DATA_BITS) return ((d / (2 ** (b - 1))) % 2) == 1;
    if (b == DATA_BITS + 1) begin
      for (int i = 0; i < DATA_BITS; i++) p += (d / (2 ** i)) % 2;
      return (p % 2) == 1;
    end
    return 1'b1;
  endfunction

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  // One stimulus slot: inputs set at negedge take effect at edge e = cyc+1.
  task automatic drive(input bit rst, input bit v, input logic [3:0] d);
    int e;
    bit rdy;
    @(negedge clk);
    e   = cyc + 1;
    rdy = (e >= next_ok);
    check(bus4.in_ready === rdy, "in_ready", int'(bus4.in_ready), int'(rdy));
    rst_n         = !rst;
    bus4.in_valid = v;
    bus4.in_data  = d;
    last_acc      = 1'b0;
    if (rst) begin
      next_ok = e + 2;
    end else if (v && rdy) begin
      last_acc = 1'b1;
      if (d <= 9) begin
        fq.push_back('{d, e});
        next_ok = e + FLEN + 1;
      end else begin
        eq.push_back(e);
        next_ok = e + 1;
      end
    end
  endtask

  // Hold a digit on the bus until the model says it was taken.
  task automatic send(input logic [3:0] d);
    for (int i = 0; i < 4 * FLEN; i++) begin
      drive(1'b0, 1'b1, d);
      if (last_acc) return;
    end
    check(1'b0, "accept_timeout", 0, 1);
  endtask

  // Monitor for the CLKS_PER_BIT=C instance.
  bit         in_frame = 1'b0;
  int         pos = 0;
  int         mism = 0;
  exp_frame_t cur;
  bit         exp_err, exp_start;
  int         want;

  always @(negedge clk) begin
    if (rst_at_edge) begin
      in_frame = 1'b0;
      fq.delete();
      eq.delete();
      check({bus4.tx_line, bus4.busy, bus4.in_ready, bus4.input_err} === 4'b1000,
            "reset_state",
            int'({bus4.tx_line, bus4.busy, bus4.in_ready, bus4.input_err}), 8);
    end else begin
      exp_err = (eq.size() > 0) && (eq[0] == cyc);
      if (exp_err || bus4.input_err !== 1'b0) begin
        check(bus4.input_err === exp_err, "input_err", int'(bus4.input_err), int'(exp_err));
        if (exp_err) void'(eq.pop_front());
      end
      if (in_frame) begin
        if (bus4.tx_line !== frame_bit(int'(cur.d), pos / C) || bus4.busy !== 1'b1) mism++;
        pos++;
        if (pos == FLEN) begin
          check(mism == 0, $sformatf("frame_digit_%0d", cur.d), mism, 0);
          in_frame = 1'b0;
        end
      end else begin
        exp_start = (fq.size() > 0) && (fq[0].start == cyc);
        if (exp_start || bus4.tx_line !== 1'b1 || bus4.busy !== 1'b0) begin
          want = exp_start ? 1 : 2;
          check({bus4.tx_line, bus4.busy} === 2'(want), "frame_start",
                int'({bus4.tx_line, bus4.busy}), want);
          if (exp_start) begin
            cur      = fq.pop_front();
            in_frame = 1'b1;
            pos      = 1;
            mism     = 0;
          end
        end
      end
    end
  end

  // Directed back-to-back 9 then 0 at one clock per bit.
  initial begin
    int  et, eb, er;
    rst1_n        = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.in_data  = 4'd0;
    repeat (2) @(negedge clk);
    rst1_n = 1'b1;
    for (int t = 0; t < 18; t++) begin
      @(negedge clk);
      if (t >= 1 && t <= 7) begin
        et = int'(frame_bit(9, t - 1)); eb = 1; er = 0;
      end else if (t >= 9 && t <= 15) begin
        et = int'(frame_bit(0, t - 9)); eb = 1; er = 0;
      end else begin
        et = 1; eb = 0; er = 1;
      end
      check({bus1.tx_line, bus1.busy, bus1.in_ready} === 3'(et * 4 + eb * 2 + er),
            $sformatf("div1_t%0d", t),
            int'({bus1.tx_line, bus1.busy, bus1.in_ready}), et * 4 + eb * 2 + er);
      if (t == 0) begin
        bus1.in_valid = 1'b1;
        bus1.in_data  = 4'd9;
      end else if (t == 1) begin
        bus1.in_data = 4'd0;
      end else if (t == 9) begin
        bus1.in_valid = 1'b0;
      end
    end
    done1 = 1'b1;
  end

  initial begin
    rst_n         = 1'b0;
    bus4.in_valid = 1'b0;
    bus4.in_data  = 4'd0;
    repeat (3) drive(1'b1, 1'b0, 4'd0);

    send(4'd5);
    send(4'd7);
    send(4'd9);
    send(4'd3);
    send(4'd12);
    send(4'd15);
    repeat (3) drive(1'b0, 1'b0, 4'd0);

    for (int i = 0; i < 400; i++) begin
      drive(1'b0, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
    end
    repeat (FLEN + 2) drive(1'b0, 1'b0, 4'd0);

    // Abort during data bit 2, with a word offered across the reset edge.
    send(4'd6);
    repeat (3 * C) drive(1'b0, 1'b0, 4'd0);
    drive(1'b1, 1'b1, 4'd4);
    repeat (FLEN + 2) drive(1'b0, 1'b0, 4'd0);
    send(4'd8);

    repeat (FLEN + 4) drive(1'b0, 1'b0, 4'd0);
    check(fq.size() == 0 && eq.size() == 0, "queue_drain", fq.size() + eq.size(), 0);
    check(done1, "div1_done", int'(done1), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
